cam_masked_search: RTL and testbench

- Parametrised successor to the lab CAM: DEPTH entries of DATA_WIDTH bits, each with a per-entry valid bit.
- Adds masked (ternary-key) search, explicit invalidate, priority-encoded hit with a multi-match flag, and an occupancy counter.
- Sits behind the bench/dut interface in the same way as the current CAM. All result outputs are registered, one-cycle latency.

---
 rtl/cam_masked_search_if.sv | 39 +++
 rtl/cam_masked_search.sv | 135 +++++++++++++
 tb/tb_cam_masked_search.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cam_masked_search_if.sv
// Request/result bundle between a CAM requester (master) and cam_masked_search (slave).
interface cam_masked_search_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 5
);
    logic                  read_i;
    logic [DEPTH_LOG2-1:0] read_index_i;
    logic                  write_i;
    logic [DEPTH_LOG2-1:0] write_index_i;
    logic [DATA_WIDTH-1:0] write_data_i;
    logic                  invalidate_i;
    logic [DEPTH_LOG2-1:0] invalidate_index_i;
    logic                  search_i;
    logic [DATA_WIDTH-1:0] search_data_i;
    logic [DATA_WIDTH-1:0] search_mask_i;
    logic                  read_valid_o;
    logic                  read_hit_o;
    logic [DATA_WIDTH-1:0] read_value_o;
    logic                  search_valid_o;
    logic                  search_hit_o;
    logic                  search_multi_o;
    logic [DEPTH_LOG2-1:0] search_index_o;
    logic [DEPTH_LOG2:0]   count_o;
    logic                  full_o;

    modport slave (
        input  read_i, read_index_i, write_i, write_index_i, write_data_i,
               invalidate_i, invalidate_index_i, search_i, search_data_i, search_mask_i,
        output read_valid_o, read_hit_o, read_value_o, search_valid_o, search_hit_o,
               search_multi_o, search_index_o, count_o, full_o
    );

    modport master (
        output read_i, read_index_i, write_i, write_index_i, write_data_i,
               invalidate_i, invalidate_index_i, search_i, search_data_i, search_mask_i,
        input  read_valid_o, read_hit_o, read_value_o, search_valid_o, search_hit_o,
               search_multi_o, search_index_o, count_o, full_o
    );
endinterface

// File: rtl/cam_masked_search.sv
// Ternary-search CAM: per-entry valid bits, masked search with priority-encoded hit,
// multi-match flag and occupancy counter. All results registered, one-cycle latency.
module cam_masked_search #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                clk,
    input  logic                reset,
    cam_masked_search_if.slave  bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;

    logic                  read_valid_q, read_valid_d;
    logic                  read_hit_q, read_hit_d;
    logic [DATA_WIDTH-1:0] read_value_q, read_value_d;
    logic                  search_valid_q, search_valid_d;
    logic                  search_hit_q, search_hit_d;
    logic                  search_multi_q, search_multi_d;
    logic [DEPTH_LOG2-1:0] search_index_q, search_index_d;

    logic [DEPTH-1:0]      match_s;
    logic [DEPTH_LOG2-1:0] low_index_s;
    logic                  inc_s, dec_s;

    // Match vector and lowest-index priority encoder over pre-edge contents
    always_comb begin
        match_s     = {DEPTH{1'b0}};
        low_index_s = {DEPTH_LOG2{1'b0}};
        for (int e = 0; e < DEPTH; e++) begin
            match_s[e] = valid_q[e] &&
                (((data_q[e] ^ bus.search_data_i) & bus.search_mask_i) == {DATA_WIDTH{1'b0}});
        end
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (match_s[e]) begin
                low_index_s = DEPTH_LOG2'(e);
            end else begin
                low_index_s = low_index_s;
            end
        end
    end

    // Valid-bit and occupancy next state; a write to the invalidated index wins
    always_comb begin
        valid_d = valid_q;
        inc_s   = bus.write_i && !valid_q[bus.write_index_i];
        dec_s   = bus.invalidate_i && valid_q[bus.invalidate_index_i] &&
                  !(bus.write_i && (bus.write_index_i == bus.invalidate_index_i));
        if (bus.invalidate_i) begin
            valid_d[bus.invalidate_index_i] = 1'b0;
        end else begin
            valid_d = valid_d;
        end
        if (bus.write_i) begin
            valid_d[bus.write_index_i] = 1'b1;
        end else begin
            valid_d = valid_d;
        end
        count_d = count_q + CNT_W'(inc_s) - CNT_W'(dec_s);
        full_d  = (count_d == CNT_W'(DEPTH));
    end

    // Read and search result next state; results hold when not requested
    always_comb begin
        read_valid_d   = bus.read_i;
        search_valid_d = bus.search_i;
        if (bus.read_i) begin
            read_hit_d   = valid_q[bus.read_index_i];
            read_value_d = valid_q[bus.read_index_i] ? data_q[bus.read_index_i]
                                                     : {DATA_WIDTH{1'b0}};
        end else begin
            read_hit_d   = read_hit_q;
            read_value_d = read_value_q;
        end
        if (bus.search_i) begin
            search_hit_d   = |match_s;
            // Clearing the lowest set bit leaves something only if 2+ entries matched
            search_multi_d = ((match_s & (match_s - DEPTH'(1))) != {DEPTH{1'b0}});
            search_index_d = low_index_s;
        end else begin
            search_hit_d   = search_hit_q;
            search_multi_d = search_multi_q;
            search_index_d = search_index_q;
        end
    end

    // Data array storage (intentionally not reset)
    always_ff @(posedge clk) begin
        if (bus.write_i) begin
            data_q[bus.write_index_i] <= bus.write_data_i;
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q        <= {DEPTH{1'b0}};
            count_q        <= {CNT_W{1'b0}};
            full_q         <= 1'b0;
            read_valid_q   <= 1'b0;
            read_hit_q     <= 1'b0;
            read_value_q   <= {DATA_WIDTH{1'b0}};
            search_valid_q <= 1'b0;
            search_hit_q   <= 1'b0;
            search_multi_q <= 1'b0;
            search_index_q <= {DEPTH_LOG2{1'b0}};
        end else begin
            valid_q        <= valid_d;
            count_q        <= count_d;
            full_q         <= full_d;
            read_valid_q   <= read_valid_d;
            read_hit_q     <= read_hit_d;
            read_value_q   <= read_value_d;
            search_valid_q <= search_valid_d;
            search_hit_q   <= search_hit_d;
            search_multi_q <= search_multi_d;
            search_index_q <= search_index_d;
        end
    end

    assign bus.read_valid_o   = read_valid_q;
    assign bus.read_hit_o     = read_hit_q;
    assign bus.read_value_o   = read_value_q;
    assign bus.search_valid_o = search_valid_q;
    assign bus.search_hit_o   = search_hit_q;
    assign bus.search_multi_o = search_multi_q;
    assign bus.search_index_o = search_index_q;
    assign bus.count_o        = count_q;
    assign bus.full_o         = full_q;
endmodule

// File: tb/tb_cam_masked_search.sv
// Directed-vector bench for cam_masked_search with hand-computed expectations.
module tb_cam_masked_search;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks_n = 0;
    int   errors_n = 0;

    cam_masked_search_if #(.DATA_WIDTH(32), .DEPTH_LOG2(5)) bus ();

    cam_masked_search #(.DATA_WIDTH(32), .DEPTH_LOG2(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.read_i = 1'b0;             bus.read_index_i = 5'd0;
        bus.write_i = 1'b0;            bus.write_index_i = 5'd0;
        bus.write_data_i = 32'd0;
        bus.invalidate_i = 1'b0;       bus.invalidate_index_i = 5'd0;
        bus.search_i = 1'b0;           bus.search_data_i = 32'd0;
        bus.search_mask_i = 32'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] d);
        idle(); bus.write_i = 1'b1; bus.write_index_i = idx; bus.write_data_i = d;
        tick();
    endtask

    task automatic do_search(input logic [31:0] key, input logic [31:0] mask);
        idle(); bus.search_i = 1'b1; bus.search_data_i = key; bus.search_mask_i = mask;
        tick();
    endtask

    task automatic do_read(input logic [4:0] idx);
        idle(); bus.read_i = 1'b1; bus.read_index_i = idx;
        tick();
    endtask

    task automatic do_inval(input logic [4:0] idx);
        idle(); bus.invalidate_i = 1'b1; bus.invalidate_index_i = idx;
        tick();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_count", 64'(bus.count_o), 64'd0);
        check_eq("rst_full", 64'(bus.full_o), 64'd0);
        check_eq("rst_rvalid", 64'(bus.read_valid_o), 64'd0);
        check_eq("rst_svalid", 64'(bus.search_valid_o), 64'd0);
        reset = 1'b1;

        // Empty CAM search
        do_search(32'h0000_0000, 32'hFFFF_FFFF);
        check_eq("empty_svalid", 64'(bus.search_valid_o), 64'd1);
        check_eq("empty_hit", 64'(bus.search_hit_o), 64'd0);
        check_eq("empty_count", 64'(bus.count_o), 64'd0);
        check_eq("empty_full", 64'(bus.full_o), 64'd0);
        idle(); tick();
        check_eq("svalid_pulse", 64'(bus.search_valid_o), 64'd0);

        // Masked search with two matches
        do_write(5'd3, 32'hDEAD_BEEF);
        do_write(5'd7, 32'hDEAD_0000);
        do_search(32'hDEAD_1234, 32'hFFFF_0000);
        check_eq("two_hit", 64'(bus.search_hit_o), 64'd1);
        check_eq("two_multi", 64'(bus.search_multi_o), 64'd1);
        check_eq("two_index", 64'(bus.search_index_o), 64'd3);
        check_eq("two_count", 64'(bus.count_o), 64'd2);

        // Invalidate lowest match
        do_inval(5'd3);
        do_search(32'hDEAD_1234, 32'hFFFF_0000);
        check_eq("inv_hit", 64'(bus.search_hit_o), 64'd1);
        check_eq("inv_multi", 64'(bus.search_multi_o), 64'd0);
        check_eq("inv_index", 64'(bus.search_index_o), 64'd7);
        check_eq("inv_count", 64'(bus.count_o), 64'd1);
        do_read(5'd3);
        check_eq("rd3_valid", 64'(bus.read_valid_o), 64'd1);
        check_eq("rd3_hit", 64'(bus.read_hit_o), 64'd0);
        check_eq("rd3_value", 64'(bus.read_value_o), 64'd0);
        do_read(5'd7);
        check_eq("rd7_hit", 64'(bus.read_hit_o), 64'd1);
        check_eq("rd7_value", 64'(bus.read_value_o), 64'hDEAD_0000);
        idle(); tick();
        check_eq("rd_pulse", 64'(bus.read_valid_o), 64'd0);
        check_eq("rd_hold", 64'(bus.read_value_o), 64'hDEAD_0000);

        // Write and search in same cycle: search sees old contents
        idle();
        bus.write_i = 1'b1; bus.write_index_i = 5'd5; bus.write_data_i = 32'h0000_0001;
        bus.search_i = 1'b1; bus.search_data_i = 32'h0000_0001; bus.search_mask_i = 32'hFFFF_FFFF;
        tick();
        check_eq("wrsrch_miss", 64'(bus.search_hit_o), 64'd0);
        do_search(32'h0000_0001, 32'hFFFF_FFFF);
        check_eq("wrsrch_hit", 64'(bus.search_hit_o), 64'd1);
        check_eq("wrsrch_index", 64'(bus.search_index_o), 64'd5);
        check_eq("wrsrch_count", 64'(bus.count_o), 64'd2);

        // Write and invalidate same index: write wins
        idle();
        bus.write_i = 1'b1; bus.write_index_i = 5'd9; bus.write_data_i = 32'h0000_0099;
        bus.invalidate_i = 1'b1; bus.invalidate_index_i = 5'd9;
        tick();
        check_eq("wi_same_count", 64'(bus.count_o), 64'd3);
        do_read(5'd9);
        check_eq("wi_same_hit", 64'(bus.read_hit_o), 64'd1);
        check_eq("wi_same_value", 64'(bus.read_value_o), 64'h99);
        do_inval(5'd9);
        check_eq("inv9_once", 64'(bus.count_o), 64'd2);
        do_inval(5'd9);
        check_eq("inv9_twice", 64'(bus.count_o), 64'd2);

        // Write and invalidate different indices: net zero
        idle();
        bus.write_i = 1'b1; bus.write_index_i = 5'd10; bus.write_data_i = 32'h0000_00AA;
        bus.invalidate_i = 1'b1; bus.invalidate_index_i = 5'd7;
        tick();
        check_eq("wi_diff_count", 64'(bus.count_o), 64'd2);
        do_read(5'd7);
        check_eq("wi_diff_rd7", 64'(bus.read_hit_o), 64'd0);

        // Fill to full, then overwrite
        for (int i = 0; i < 32; i++) begin
            do_write(5'(i), 32'h1000_0000 + 32'(i));
        end
        check_eq("fill_count", 64'(bus.count_o), 64'd32);
        check_eq("fill_full", 64'(bus.full_o), 64'd1);
        do_write(5'd0, 32'h2000_0000);
        check_eq("ovw_count", 64'(bus.count_o), 64'd32);
        check_eq("ovw_full", 64'(bus.full_o), 64'd1);
        do_search(32'h1000_0007, 32'hFFFF_FFFF);
        check_eq("exact_hit", 64'(bus.search_hit_o), 64'd1);
        check_eq("exact_multi", 64'(bus.search_multi_o), 64'd0);
        check_eq("exact_index", 64'(bus.search_index_o), 64'd7);
        do_search(32'h0000_0000, 32'h0000_0000);
        check_eq("dc_hit", 64'(bus.search_hit_o), 64'd1);
        check_eq("dc_multi", 64'(bus.search_multi_o), 64'd1);
        check_eq("dc_index", 64'(bus.search_index_o), 64'd0);
        do_search(32'h1000_001F, 32'h0000_00F0);
        check_eq("nib_index", 64'(bus.search_index_o), 64'd16);

        // Reset mid-search
        idle();
        bus.search_i = 1'b1; bus.search_mask_i = 32'h0000_0000;
        #2;
        reset = 1'b0;
        #1;
        check_eq("midrst_svalid", 64'(bus.search_valid_o), 64'd0);
        check_eq("midrst_hit", 64'(bus.search_hit_o), 64'd0);
        check_eq("midrst_count", 64'(bus.count_o), 64'd0);
        check_eq("midrst_full", 64'(bus.full_o), 64'd0);
        tick();
        check_eq("midrst_held", 64'(bus.search_valid_o), 64'd0);
        reset = 1'b1;
        do_search(32'h0000_0000, 32'h0000_0000);
        check_eq("postrst_svalid", 64'(bus.search_valid_o), 64'd1);
        check_eq("postrst_hit", 64'(bus.search_hit_o), 64'd0);
        check_eq("postrst_count", 64'(bus.count_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end
endmodule
